// File: rtl/q2a03_pkg.sv
// q2a03_pkg: shared types and constants for the 2A03 slice.
//   reg8 / reg16       byte and bus-address types
//   DEF_TRIGGER_ADDR   default CPU write address that starts an OAM DMA
//   DEF_OAM_DATA_ADDR  default destination address of every DMA put cycle
//   dma_state_t        OAM DMA controller states
package q2a03_pkg;

    typedef logic [7:0]  reg8;
    typedef logic [15:0] reg16;

    localparam reg16 DEF_TRIGGER_ADDR  = 16'h4014;
    localparam reg16 DEF_OAM_DATA_ADDR = 16'h2004;

    typedef enum logic [2:0] {
        StIdle,
        StHalt,
        StAlign,
        StGet,
        StPut
    } dma_state_t;

endpackage

// File: rtl/q2a03_phase_edge.sv
// q2a03_phase_edge: falling-edge detector for a slow phase clock sampled in
// the G_clock domain.
//   G_clock  in   master clock
//   G_reset  in   asynchronous, active-low reset
//   phase    in   phase clock to watch (e.g. G_phy2)
//   fall     out  high for the one G_clock where phase was 1 last clock and is 0 now
module q2a03_phase_edge (
    input  logic G_clock,
    input  logic G_reset,
    input  logic phase,
    output logic fall
);

    logic phase_q;

    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            phase_q <= 1'b0;
        end else begin
            phase_q <= phase;
        end
    end

    // Combinational against the live input so the owner acts on the same edge.
    assign fall = phase_q & ~phase;

endmodule

// File: rtl/q2a03_oam_dma.sv
// q2a03_oam_dma: sprite OAM DMA controller. A CPU write to P_TRIGGER_ADDR halts
// the CPU and copies the 256-byte page {data,8'h00..8'hFF} to P_OAM_DATA_ADDR,
// one get/put pair per two CPU cycles.
//   G_clock, G_reset     master clock, asynchronous active-low reset
//   G_phy2               CPU phase-2; its falling edge ends a CPU cycle
//   cpu_addr/cpu_wr_data/cpu_rdwr/cpu_rd_data/cpu_ready   CPU side of the bus
//   G_addr/G_wr_data/G_rdwr/G_rd_data/G_ready             system side of the bus
//   dma_active           high in every state but idle
// Optional build macro: Q2A03_OAM_DMA_DEBUG_EN adds a completed-transfer counter
// and the task read_dma_state (state, page, index, count).
module q2a03_oam_dma
    import q2a03_pkg::*;
#(
    parameter reg16 P_TRIGGER_ADDR  = DEF_TRIGGER_ADDR,
    parameter reg16 P_OAM_DATA_ADDR = DEF_OAM_DATA_ADDR
) (
    input  logic        G_clock,
    input  logic        G_reset,
    input  logic        G_phy2,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wr_data,
    input  logic        cpu_rdwr,
    output logic [7:0]  cpu_rd_data,
    output logic        cpu_ready,
    input  logic        G_ready,
    output logic [15:0] G_addr,
    output logic [7:0]  G_wr_data,
    output logic        G_rdwr,
    input  logic [7:0]  G_rd_data,
    output logic        dma_active
);

    dma_state_t state;
    reg8        page;
    reg8        index;
    reg8        data;
    logic       parity;   // slot of the current CPU cycle: 0 = get, 1 = put
    logic       boundary;
    logic       trigger;

    q2a03_phase_edge u_phase_edge (
        .G_clock (G_clock),
        .G_reset (G_reset),
        .phase   (G_phy2),
        .fall    (boundary)
    );

    assign trigger = (cpu_addr == P_TRIGGER_ADDR) && !cpu_rdwr;

    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            state  <= StIdle;
            parity <= 1'b0;
            page   <= '0;
            index  <= '0;
            data   <= '0;
        end else if (boundary) begin
            parity <= ~parity;
            unique case (state)
                StIdle: begin
                    if (trigger) begin
                        page  <= cpu_wr_data;
                        index <= '0;
                        state <= StHalt;
                    end
                end
                // The next slot has parity ~parity; gets must land on even slots.
                StHalt:  if (G_ready) state <= parity ? StGet : StAlign;
                StAlign: if (G_ready) state <= StGet;
                StGet: begin
                    if (G_ready) begin
                        data  <= G_rd_data;
                        state <= StPut;
                    end
                end
                StPut: begin
                    if (G_ready) begin
                        index <= index + 8'd1;
                        state <= (index == 8'hFF) ? StIdle : StGet;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign dma_active = (state != StIdle);

    always_comb begin
        cpu_rd_data = G_rd_data;
        cpu_ready   = G_ready;
        G_addr      = cpu_addr;
        G_wr_data   = cpu_wr_data;
        G_rdwr      = cpu_rdwr;
        unique case (state)
            StIdle: begin
            end
            // CPU is halted; its address is shown but its writes are suppressed.
            StHalt, StAlign: begin
                cpu_ready = 1'b0;
                G_rdwr    = 1'b1;
            end
            StGet: begin
                cpu_ready = 1'b0;
                G_addr    = {page, index};
                G_rdwr    = 1'b1;
            end
            StPut: begin
                cpu_ready = 1'b0;
                G_addr    = P_OAM_DATA_ADDR;
                G_rdwr    = 1'b0;
                G_wr_data = data;
            end
            default: begin
            end
        endcase
    end

`ifdef Q2A03_OAM_DMA_DEBUG_EN
    logic [31:0] xfer_count;

    always_ff @(posedge G_clock or negedge G_reset) begin
        if (!G_reset) begin
            xfer_count <= '0;
        end else if (boundary && (state == StPut) && G_ready && (index == 8'hFF)) begin
            xfer_count <= xfer_count + 32'd1;
        end
    end

    task read_dma_state(output logic [2:0] st, output logic [7:0] pg,
                        output logic [7:0] idx, output logic [31:0] count);
        st    = state;
        pg    = page;
        idx   = index;
        count = xfer_count;
    endtask
`else
`endif

endmodule
